// File: rtl/mtimer_cmp_bank_if.sv
// Bus bundle for the machine-timer compare bank: 32-bit word-addressed
// register port plus the per-channel level interrupts.
interface mtimer_cmp_bank_if #(
  parameter int unsigned NCMP = 2
);
  logic            wr_en;
  logic            rd_en;
  logic [7:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            rvalid;
  logic [NCMP-1:0] irq;

  // Bus master (core side): issues accesses, consumes read data and interrupts.
  modport master (
    output wr_en,
    output rd_en,
    output addr,
    output wdata,
    input  rdata,
    input  rvalid,
    input  irq
  );

  // Timer block side.
  modport slave (
    input  wr_en,
    input  rd_en,
    input  addr,
    input  wdata,
    output rdata,
    output rvalid,
    output irq
  );
endinterface

// File: rtl/mtimer_cmp_bank.sv
// Machine timer with prescaler and NCMP compare channels.
// Word map: 0/1 mtime lo/hi, 2 CTRL {DIV at [8+:PRESC_W], EN at [0]},
// 3 IRQ_STAT (read-only), 4+2k/5+2k compare k lo/hi. Other words read 0.
// A compare lo write disarms the channel until its hi write, so a two-step
// 64-bit update cannot glitch the interrupt.
module mtimer_cmp_bank #(
  parameter int unsigned TIMER_W = 64,
  parameter int unsigned NCMP    = 2,
  parameter int unsigned PRESC_W = 8
) (
  input logic              clk,
  input logic              rst,
  mtimer_cmp_bank_if.slave bus
);

  localparam int unsigned HiW = TIMER_W - 32;

  // State
  logic [TIMER_W-1:0] r_mtime;
  logic [PRESC_W-1:0] r_presc;
  logic               r_en;
  logic [PRESC_W-1:0] r_div;
  logic [TIMER_W-1:0] r_cmp [NCMP];
  logic [NCMP-1:0]    r_arm;
  logic [NCMP-1:0]    r_irq;
  logic [31:0]        r_rdata;
  logic               r_rvalid;

  // Next-state / decode
  logic               w_wr_mtime_lo;
  logic               w_wr_mtime_hi;
  logic               w_wr_ctrl;
  logic [NCMP-1:0]    w_wr_cmp_lo;
  logic [NCMP-1:0]    w_wr_cmp_hi;
  logic               w_tick;
  logic [PRESC_W-1:0] w_presc_d;
  logic [TIMER_W-1:0] w_mtime_inc;
  logic [TIMER_W-1:0] w_mtime_d;
  logic [TIMER_W-1:0] w_cmp_d [NCMP];
  logic [NCMP-1:0]    w_arm_d;
  logic [NCMP-1:0]    w_irq_d;
  logic [31:0]        w_ctrl_word;
  logic [31:0]        w_rd_word;

  // Write address decode
  always_comb begin
    w_wr_mtime_lo = bus.wr_en && (bus.addr == 8'd0);
    w_wr_mtime_hi = bus.wr_en && (bus.addr == 8'd1);
    w_wr_ctrl     = bus.wr_en && (bus.addr == 8'd2);
    for (int k = 0; k < NCMP; k++) begin
      w_wr_cmp_lo[k] = bus.wr_en && (bus.addr == 8'(4 + 2 * k));
      w_wr_cmp_hi[k] = bus.wr_en && (bus.addr == 8'(5 + 2 * k));
    end
  end

  assign w_tick = r_en && (r_presc == r_div);

  // Prescaler: any mtime or CTRL write restarts the divide period
  always_comb begin
    w_presc_d = r_presc;
    if (w_wr_mtime_lo || w_wr_mtime_hi || w_wr_ctrl) begin
      w_presc_d = '0;
    end else if (r_en) begin
      w_presc_d = w_tick ? '0 : r_presc + PRESC_W'(1);
    end
  end

  // mtime: a half-word write wins over the tick, so no carry leaks across halves
  always_comb begin
    w_mtime_inc = r_mtime + TIMER_W'(1);
    w_mtime_d   = r_mtime;
    if (w_wr_mtime_lo) begin
      w_mtime_d[31:0] = bus.wdata;
    end else if (w_wr_mtime_hi) begin
      w_mtime_d[TIMER_W-1:32] = bus.wdata[HiW-1:0];
    end else if (w_tick) begin
      w_mtime_d = w_mtime_inc;
    end
  end

  // Compare registers, arm flags and interrupt levels (from pre-update values)
  always_comb begin
    for (int k = 0; k < NCMP; k++) begin
      w_cmp_d[k] = r_cmp[k];
      w_arm_d[k] = r_arm[k];
      if (w_wr_cmp_lo[k]) begin
        w_cmp_d[k][31:0] = bus.wdata;
        w_arm_d[k]       = 1'b0;
      end
      if (w_wr_cmp_hi[k]) begin
        w_cmp_d[k][TIMER_W-1:32] = bus.wdata[HiW-1:0];
        w_arm_d[k]               = 1'b1;
      end
      w_irq_d[k] = r_arm[k] && (r_mtime >= r_cmp[k]);
    end
  end

  // Read data mux over current register values
  always_comb begin
    w_ctrl_word                = '0;
    w_ctrl_word[0]             = r_en;
    w_ctrl_word[8 +: PRESC_W]  = r_div;
    w_rd_word                  = '0;
    case (bus.addr)
      8'd0:    w_rd_word = r_mtime[31:0];
      8'd1:    w_rd_word[HiW-1:0] = r_mtime[TIMER_W-1:32];
      8'd2:    w_rd_word = w_ctrl_word;
      8'd3:    w_rd_word[NCMP-1:0] = r_irq;
      default: ;
    endcase
    for (int k = 0; k < NCMP; k++) begin
      if (bus.addr == 8'(4 + 2 * k)) begin
        w_rd_word = r_cmp[k][31:0];
      end
      if (bus.addr == 8'(5 + 2 * k)) begin
        w_rd_word          = '0;
        w_rd_word[HiW-1:0] = r_cmp[k][TIMER_W-1:32];
      end
    end
  end

  // Timer and prescaler state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= '0;
      r_presc <= '0;
    end else begin
      r_mtime <= w_mtime_d;
      r_presc <= w_presc_d;
    end
  end

  // Control register; EN comes out of reset set so the timer runs by default
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en  <= 1'b1;
      r_div <= '0;
    end else if (w_wr_ctrl) begin
      r_en  <= bus.wdata[0];
      r_div <= bus.wdata[8 +: PRESC_W];
    end
  end

  // Compare channels; all-ones reset keeps interrupts quiet until programmed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCMP; k++) begin
        r_cmp[k] <= '1;
      end
      r_arm <= '1;
      r_irq <= '0;
    end else begin
      for (int k = 0; k < NCMP; k++) begin
        r_cmp[k] <= w_cmp_d[k];
      end
      r_arm <= w_arm_d;
      r_irq <= w_irq_d;
    end
  end

  // Registered read port; rdata holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.irq    = r_irq;

endmodule

// File: tb/tb_mtimer_cmp_bank.sv
// Directed bench for mtimer_cmp_bank (TIMER_W=64, NCMP=2, PRESC_W=8).
// Inputs change and outputs are sampled on the falling edge; every task
// below spans exactly one rising edge so the cycle arithmetic stays exact.
module tb_mtimer_cmp_bank;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  mtimer_cmp_bank_if #(.NCMP(2)) bus ();

  mtimer_cmp_bank #(
    .TIMER_W(64),
    .NCMP   (2),
    .PRESC_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check({tag, ".rvalid"}, 64'(bus.rvalid), 64'd1);
    check(tag, 64'(bus.rdata), 64'(exp));
  endtask

  task automatic rw(input string tag, input logic [7:0] a, input logic [31:0] d,
                    input logic [31:0] exp);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check(tag, 64'(bus.rdata), 64'(exp));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset values; first read lands on the first edge after release (mtime still 0)
    idle(3);
    check("rst.irq", 64'(bus.irq), 64'd0);
    check("rst.rvalid", 64'(bus.rvalid), 64'd0);
    check("rst.rdata", 64'(bus.rdata), 64'd0);
    rst = 1'b0;
    rd("rst.mtime_lo", 8'd0, 32'h0);
    rd("rst.mtime_hi", 8'd1, 32'h0);
    rd("rst.cmp0_lo", 8'd4, 32'hFFFF_FFFF);
    rd("rst.cmp0_hi", 8'd5, 32'hFFFF_FFFF);
    rd("rst.ctrl", 8'd2, 32'h0000_0001);
    idle(1);
    check("rvalid_drop", 64'(bus.rvalid), 64'd0);
    check("rdata_hold", 64'(bus.rdata), 64'd1);
    check("irq_quiet", 64'(bus.irq), 64'd0);

    // DIV=3: mtime zeroed on the 2nd write, ticks every 4th edge afterwards
    wr(8'd2, 32'h0000_0301);
    wr(8'd0, 32'h0);
    wr(8'd4, 32'd10);
    wr(8'd5, 32'd0);
    idle(1);
    rd("div.pre_tick", 8'd0, 32'd0);
    rd("div.tick1", 8'd0, 32'd1);
    idle(2);
    rd("div.pre_tick2", 8'd0, 32'd1);
    rd("div.tick2", 8'd0, 32'd2);
    idle(31);
    // mtime has just become 10; irq follows one edge later
    check("irq.before", 64'(bus.irq), 64'd0);
    rd("irq.mtime10", 8'd0, 32'd10);
    check("irq.latency", 64'(bus.irq), 64'b01);

    // Disarm via cmp lo write, then re-arm via hi
    wr(8'd4, 32'h1000);
    idle(1);
    check("disarm.clear", 64'(bus.irq), 64'd0);
    wr(8'd0, 32'h2000);
    idle(3);
    check("disarm.hold", 64'(bus.irq), 64'd0);
    wr(8'd5, 32'd0);
    check("rearm.edge", 64'(bus.irq), 64'd0);
    idle(1);
    check("rearm.irq", 64'(bus.irq), 64'b01);
    wr(8'd5, 32'd1);
    idle(1);
    check("cmp_above.clear", 64'(bus.irq), 64'd0);
    wr(8'd5, 32'd0);
    idle(1);
    check("hi_only.armed", 64'(bus.irq), 64'b01);

    // Carry from lo into hi with DIV=0, frozen right after the second tick
    wr(8'd2, 32'h1);
    wr(8'd1, 32'h0);
    wr(8'd0, 32'hFFFF_FFFE);
    idle(1);
    wr(8'd2, 32'h0);
    rd("carry.hi", 8'd1, 32'd1);
    rd("carry.lo", 8'd0, 32'd0);

    // Compare at all-ones only fires when mtime is all-ones
    wr(8'd0, 32'hFFFF_FFFF);
    wr(8'd1, 32'hFFFF_FFFF);
    idle(1);
    check("allones.irq", 64'(bus.irq), 64'b11);
    wr(8'd0, 32'hFFFF_FFFE);
    idle(1);
    check("allones.below", 64'(bus.irq), 64'b01);
    wr(8'd0, 32'hFFFF_FFFF);
    wr(8'd6, 32'd5);
    wr(8'd7, 32'd0);
    idle(1);
    check("cmp1_5.irq", 64'(bus.irq), 64'b11);
    rd("irq_stat", 8'd3, 32'h3);
    rd("cmp1_lo", 8'd6, 32'd5);

    // Wrap: enable with DIV=0, next edge wraps to 0, irq drops one edge later
    wr(8'd2, 32'h1);
    check("wrap.pre", 64'(bus.irq), 64'b11);
    idle(1);
    check("wrap.edge", 64'(bus.irq), 64'b11);
    rd("wrap.mtime_lo", 8'd0, 32'd0);
    check("wrap.irq_drop", 64'(bus.irq), 64'd0);
    rd("wrap.mtime_hi", 8'd1, 32'd0);

    // Write in a tick cycle wins; next tick DIV+1 edges later
    wr(8'd2, 32'h0000_0301);
    idle(3);
    wr(8'd0, 32'h20);
    rd("prec.no_inc", 8'd0, 32'h20);
    idle(2);
    rd("prec.pre_tick", 8'd0, 32'h20);
    rd("prec.tick", 8'd0, 32'h21);

    // EN=0 freezes mtime
    wr(8'd2, 32'h0000_0300);
    rd("freeze.a", 8'd0, 32'h21);
    idle(50);
    rd("freeze.b", 8'd0, 32'h21);
    rd("freeze.hi", 8'd1, 32'h0);
    rd("ctrl.readback", 8'd2, 32'h0000_0300);

    // Unmapped words
    wr(8'd8, 32'h1234);
    rd("unmapped.8", 8'd8, 32'h0);
    rd("unmapped.80", 8'h80, 32'h0);

    // Same-cycle read and write: read sees the old value
    rw("rw.old", 8'd0, 32'h55, 32'h21);
    rd("rw.new", 8'd0, 32'h55);

    // Async reset pulse right after a read edge with both irqs high
    wr(8'd4, 32'h10);
    wr(8'd5, 32'h0);
    idle(1);
    check("arst.pre_irq", 64'(bus.irq), 64'b11);
    bus.rd_en = 1'b1;
    bus.addr  = 8'd0;
    @(posedge clk);
    #2;
    check("arst.pre_rvalid", 64'(bus.rvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("arst.irq", 64'(bus.irq), 64'd0);
    check("arst.rvalid", 64'(bus.rvalid), 64'd0);
    check("arst.rdata", 64'(bus.rdata), 64'd0);
    bus.rd_en = 1'b0;
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("arst.rvalid_after", 64'(bus.rvalid), 64'd0);
    rd("arst.mtime_lo", 8'd0, 32'h0);
    rd("arst.mtime_hi", 8'd1, 32'h0);
    rd("arst.cmp0_lo", 8'd4, 32'hFFFF_FFFF);
    rd("arst.cmp0_hi", 8'd5, 32'hFFFF_FFFF);
    rd("arst.cmp1_lo", 8'd6, 32'hFFFF_FFFF);
    rd("arst.cmp1_hi", 8'd7, 32'hFFFF_FFFF);
    rd("arst.ctrl", 8'd2, 32'h0000_0001);
    rd("arst.irq_stat", 8'd3, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
